// File: rtl/ram_arbiter_if.sv
// Bundle of the signals shared by the two RAM requesters (CPU, DMA) and the single RAM port.
// The arbiter connects through the slave modport. The requesters and the RAM connect through the master modport.
interface ram_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             cpu_req;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic [1:0]       cpu_wflag;
    logic [2:0]       cpu_lflag;
    logic             cpu_ack;
    logic             cpu_stall;
    logic [31:0]      cpu_rdata;

    logic             dma_req;
    logic [31:0]      dma_addr;
    logic [31:0]      dma_wdata;
    logic [1:0]       dma_wflag;
    logic [2:0]       dma_lflag;
    logic             dma_ack;
    logic [31:0]      dma_rdata;

    logic [31:0]      ram_addr;
    logic [31:0]      write_ram_data;
    logic [1:0]       write_ram_flag;
    logic [2:0]       load_ram_flag;
    logic [31:0]      ram_out;

    logic [CNT_W-1:0] contention_cnt;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_wflag, cpu_lflag,
        input  dma_req, dma_addr, dma_wdata, dma_wflag, dma_lflag,
        input  ram_out,
        output cpu_ack, cpu_stall, cpu_rdata, dma_ack, dma_rdata,
        output ram_addr, write_ram_data, write_ram_flag, load_ram_flag,
        output contention_cnt
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_wflag, cpu_lflag,
        output dma_req, dma_addr, dma_wdata, dma_wflag, dma_lflag,
        output ram_out,
        input  cpu_ack, cpu_stall, cpu_rdata, dma_ack, dma_rdata,
        input  ram_addr, write_ram_data, write_ram_flag, load_ram_flag,
        input  contention_cnt
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for the single data RAM port, shared by the CPU load/store path and the DMA port.
// Each grant is a complete 0-latency transaction. The burst limit bounds how long either side can be starved.
module ram_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    owner_e           owner_q, owner_d, winner;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             both_req;
    logic             cpu_gnt, dma_gnt;

    assign both_req = bus.cpu_req & bus.dma_req;

    // Under contention, the current owner keeps the port until it has used MAX_BURST grants in a row.
    always_comb begin
        winner = OWN_NONE;
        if (both_req) begin
            unique case (owner_q)
                OWN_CPU: winner = (bcnt_q < MAX_B) ? OWN_CPU : OWN_DMA;
                OWN_DMA: winner = (bcnt_q < MAX_B) ? OWN_DMA : OWN_CPU;
                default: winner = OWN_CPU;
            endcase
        end else if (bus.cpu_req) begin
            winner = OWN_CPU;
        end else if (bus.dma_req) begin
            winner = OWN_DMA;
        end
    end

    assign cpu_gnt = (winner == OWN_CPU) & ~rst;
    assign dma_gnt = (winner == OWN_DMA) & ~rst;

    always_comb begin
        bus.cpu_ack        = cpu_gnt;
        bus.dma_ack        = dma_gnt;
        bus.cpu_stall      = bus.cpu_req & ~cpu_gnt;
        bus.cpu_rdata      = '0;
        bus.dma_rdata      = '0;
        bus.ram_addr       = '0;
        bus.write_ram_data = '0;
        bus.write_ram_flag = '0;
        bus.load_ram_flag  = '0;
        if (cpu_gnt) begin
            bus.ram_addr       = bus.cpu_addr;
            bus.write_ram_data = bus.cpu_wdata;
            bus.write_ram_flag = bus.cpu_wflag;
            bus.load_ram_flag  = bus.cpu_lflag;
            bus.cpu_rdata      = bus.ram_out;
        end else if (dma_gnt) begin
            bus.ram_addr       = bus.dma_addr;
            bus.write_ram_data = bus.dma_wdata;
            bus.write_ram_flag = bus.dma_wflag;
            bus.load_ram_flag  = bus.dma_lflag;
            bus.dma_rdata      = bus.ram_out;
        end
    end

    assign bus.contention_cnt = cnt_q;

    always_comb begin
        owner_d = winner;
        bcnt_d  = '0;
        cnt_d   = cnt_q;
        if (winner != OWN_NONE) begin
            if (winner != owner_q) begin
                bcnt_d = 4'd1;
            end else if (bcnt_q == 4'hF) begin
                bcnt_d = bcnt_q;
            end else begin
                bcnt_d = bcnt_q + 4'd1;
            end
        end
        if (both_req && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            bcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
